// File: rtl/decode_stage.sv
// RV32I multi-lane decode stage: per-lane combinational decoders feeding a
// 2-entry skid FIFO so fetch can keep streaming while dispatch stalls.

module decode_lane #(
  parameter int XLEN  = 32,
  parameter int UOP_W = XLEN + 45
) (
  input  logic [31:0]      instr,
  input  logic             lane_valid,
  output logic [UOP_W-1:0] uop
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic has_imm;
    logic reg_write;
    logic alu_src;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1, rs2, rd_raw;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  ctrl_t           ctrl;
  logic [1:0]      alu_op;
  logic [1:0]      lw_sw;
  logic            illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd_raw = instr[11:7];

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    imm     = '0;
    rd      = rd_raw;
    ctrl    = '0;
    alu_op  = 2'b00;
    lw_sw   = 2'b00;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        alu_op         = 2'b10;
      end
      OP_IALU: begin
        ctrl.has_imm   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        alu_op         = 2'b10;
        imm            = imm_i;
      end
      OP_LOAD: begin
        ctrl.has_imm    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        lw_sw           = 2'b01;
        imm             = imm_i;
      end
      OP_STORE: begin
        ctrl.has_imm   = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        lw_sw          = 2'b10;
        imm            = imm_s;
        rd             = '0;
      end
      OP_BRANCH: begin
        ctrl.has_imm = 1'b1;
        ctrl.branch  = 1'b1;
        alu_op       = 2'b01;
        imm          = imm_b;
        rd           = '0;
      end
      OP_JAL, OP_JALR: begin
        ctrl.has_imm   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.branch    = 1'b1;
        imm            = (opcode == OP_JAL) ? imm_j : imm_i;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl.has_imm   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm            = imm_u;
      end
      default: illegal = 1'b1;
    endcase
  end

  // An invalid lane must be all-zero so downstream can ignore it without checking fields.
  assign uop = lane_valid
             ? {1'b1, illegal, lw_sw, alu_op, ctrl, imm, rd, rs2, rs1, funct7, funct3, opcode}
             : '0;

endmodule

module decode_stage #(
  parameter int XLEN  = 32,
  parameter int WIDTH = 2,
  parameter int PC_W  = 32,
  parameter int UOP_W = XLEN + 45
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*32-1:0]    in_instr,
  input  logic [WIDTH-1:0]       in_lane_valid,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [WIDTH*UOP_W-1:0] out_uop
);

  typedef struct packed {
    logic [PC_W-1:0]               pc;
    logic [WIDTH-1:0][UOP_W-1:0]   uop;
  } entry_t;

  logic [WIDTH-1:0][UOP_W-1:0] dec_uop;
  entry_t                      incoming;
  entry_t                      head, tail;
  logic [1:0]                  count;
  logic                        accept, pop;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    decode_lane #(.XLEN(XLEN), .UOP_W(UOP_W)) u_lane (
      .instr      (in_instr[32*i +: 32]),
      .lane_valid (in_lane_valid[i]),
      .uop        (dec_uop[i])
    );
  end

  assign incoming.pc  = in_pc;
  assign incoming.uop = dec_uop;

  // in_ready depends only on occupancy, never on out_ready, to keep the path registered.
  assign in_ready  = rstn & (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_pc  = head.pc;
  assign out_uop = head.uop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (count == 2'd0) head <= incoming;
          else               tail <= incoming;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        // Simultaneous accept and pop can only happen with one entry held.
        2'b11: head <= incoming;
        default: ;
      endcase
    end
  end

endmodule
